// File: rtl/ps2_key_event_decoder.sv
// ps2_key_event_decoder: scan-code set 2 parser with held-key table for typematic suppression
module ps2_key_event_decoder #(
  parameter int NUM_SLOTS      = 8,
  parameter int TIMEOUT_CYCLES = 250000
) (
  input  logic                           CLOCK_50,
  input  logic                           reset,
  input  logic [7:0]                     received_data,
  input  logic                           received_data_en,
  output logic [7:0]                     key_code,
  output logic                           key_extended,
  output logic                           key_make,
  output logic                           key_event,
  output logic [$clog2(NUM_SLOTS+1)-1:0] held_count,
  output logic                           table_full,
  output logic                           seq_error
);
  localparam int CW = $clog2(NUM_SLOTS+1);
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [NUM_SLOTS-1:0] valid_q, valid_d, sext_q, hit, free_oh, wr;
  logic [7:0] scode_q [NUM_SLOTS];
  logic [7:0] code_q;
  logic ext_q, make_q, event_q, err_q;
  logic mk, bk, err, ext, pre, ign, expire, press, rel;
  logic [CW-1:0] cnt;
  assign ext     = state_q == EXT || state_q == EXT_BRK;
  assign pre     = received_data == 8'hE0 || received_data == 8'hF0;
  assign ign     = received_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  assign expire  = state_q != IDLE && timer_q == TW'(TIMEOUT_CYCLES-1);
  assign free_oh = ~valid_q & (valid_q + 1'b1);
  assign press   = mk && !(|hit) && |free_oh;
  assign rel     = bk && |hit;
  assign wr      = press ? free_oh : '0;
  assign valid_d = (valid_q | wr) & ~(rel ? hit : '0);
  assign timer_d = (received_data_en || state_q == IDLE || expire) ? '0 : timer_q + 1'b1;
  assign key_code     = code_q;
  assign key_extended = ext_q;
  assign key_make     = make_q;
  assign key_event    = event_q;
  assign seq_error    = err_q;
  assign held_count   = cnt;
  assign table_full   = cnt == CW'(NUM_SLOTS);
  // Match incoming code against every slot and count occupied slots
  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      hit[i] = valid_q[i] && sext_q[i] == ext && scode_q[i] == received_data;
      cnt = cnt + CW'(valid_q[i]);
    end
  end
  // Prefix FSM: decides make/break/error for the current byte or an idle timeout
  always_comb begin
    state_d = state_q;
    mk = 1'b0;
    bk = 1'b0;
    err = 1'b0;
    if (received_data_en)
      case (state_q)
        IDLE: begin
          state_d = received_data == 8'hE0 ? EXT : received_data == 8'hF0 ? BRK : IDLE;
          mk = !pre && !ign;
        end
        EXT: begin
          state_d = received_data == 8'hF0 ? EXT_BRK : received_data == 8'hE0 ? EXT : IDLE;
          err = received_data == 8'hE0;
          mk = !pre;
        end
        default: begin
          state_d = IDLE;
          err = pre;
          bk = !pre;
        end
      endcase
    else if (expire) begin
      state_d = IDLE;
      err = 1'b1;
    end
  end
  // State, timer, slot valid bits and registered event outputs
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      valid_q <= '0;
      code_q  <= '0;
      ext_q   <= 1'b0;
      make_q  <= 1'b0;
      event_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      valid_q <= valid_d;
      event_q <= press || rel;
      err_q   <= err;
      if (press || rel) begin
        code_q <= received_data;
        ext_q  <= ext;
        make_q <= press;
      end
    end
  end
  // Slot payload written only when a press claims the slot
  always_ff @(posedge CLOCK_50) begin
    for (int i = 0; i < NUM_SLOTS; i++)
      if (wr[i]) begin
        scode_q[i] <= received_data;
        sext_q[i]  <= ext;
      end
  end
endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// tb_ps2_key_event_decoder: random and directed byte streams checked against a key-table model
module tb_ps2_key_event_decoder;
  localparam int N = 8;
  localparam int T = 40;
  logic clk = 1'b0;
  logic rst, en;
  logic [7:0] data;
  logic [7:0] key_code;
  logic key_extended, key_make, key_event, table_full, seq_error;
  logic [3:0] held_count;
  int total = 0, passed = 0;
  bit me0, mf0;
  int idle;
  bit mv [N];
  bit mx [N];
  logic [7:0] mc [N];
  logic [7:0] exp_code;
  bit exp_ext, exp_make, exp_ev, exp_err;
  logic [7:0] codes [12] = '{8'h1C, 8'h75, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h12};
  logic [7:0] igns [7] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  logic [7:0] full_set [8] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43};

  ps2_key_event_decoder #(.NUM_SLOTS(N), .TIMEOUT_CYCLES(T)) dut (
    .CLOCK_50(clk), .reset(rst), .received_data(data), .received_data_en(en),
    .key_code(key_code), .key_extended(key_extended), .key_make(key_make),
    .key_event(key_event), .held_count(held_count), .table_full(table_full),
    .seq_error(seq_error));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
  endtask

  function automatic int held();
    int n = 0;
    for (int i = 0; i < N; i++) n += int'(mv[i]);
    return n;
  endfunction

  function automatic void report(input bit e, input logic [7:0] c, input bit m);
    exp_ev = 1;
    exp_code = c;
    exp_ext = e;
    exp_make = m;
  endfunction

  function automatic void do_make(input bit e, input logic [7:0] c);
    for (int i = 0; i < N; i++) if (mv[i] && mx[i] == e && mc[i] == c) return;
    for (int i = 0; i < N; i++)
      if (!mv[i]) begin
        mv[i] = 1; mx[i] = e; mc[i] = c;
        report(e, c, 1);
        return;
      end
  endfunction

  function automatic void do_break(input bit e, input logic [7:0] c);
    for (int i = 0; i < N; i++)
      if (mv[i] && mx[i] == e && mc[i] == c) begin
        mv[i] = 0;
        report(e, c, 0);
        return;
      end
  endfunction

  function automatic bit is_ign(input logic [7:0] b);
    foreach (igns[i]) if (igns[i] == b) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    exp_ev = 0;
    exp_err = 0;
    if (rst) begin
      me0 = 0; mf0 = 0; idle = 0;
      foreach (mv[i]) mv[i] = 0;
      exp_code = 0; exp_ext = 0; exp_make = 0;
    end else if (en) begin
      idle = 0;
      if (mf0) begin
        if (data == 8'hE0 || data == 8'hF0) exp_err = 1;
        else do_break(me0, data);
        me0 = 0; mf0 = 0;
      end else if (me0) begin
        if (data == 8'hF0) mf0 = 1;
        else if (data == 8'hE0) exp_err = 1;
        else begin do_make(1, data); me0 = 0; end
      end else if (data == 8'hE0) me0 = 1;
      else if (data == 8'hF0) mf0 = 1;
      else if (!is_ign(data)) do_make(0, data);
    end else if (me0 || mf0) begin
      if (idle == T-1) begin exp_err = 1; me0 = 0; mf0 = 0; idle = 0; end
      else idle++;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("key_event", key_event, exp_ev);
    chk("seq_error", seq_error, exp_err);
    chk("key_code", key_code, exp_code);
    chk("key_extended", key_extended, exp_ext);
    chk("key_make", key_make, exp_make);
    chk("held_count", held_count, held());
    chk("table_full", table_full, held() == N);
  end

  task automatic put(input logic [7:0] b, input int gap);
    @(negedge clk);
    en = 1; data = b;
    if (gap > 0) begin
      @(negedge clk);
      en = 0;
      repeat (gap-1) @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] b);
    put(b, 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    en = 0; rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    int errs;
    logic [7:0] b;
    int r, g, gap;
    rst = 1; en = 0; data = 0;
    repeat (2) @(negedge clk);
    chk("rst_event", key_event, 0);
    chk("rst_held", held_count, 0);
    chk("rst_full", table_full, 0);
    chk("rst_err", seq_error, 0);
    chk("rst_code", key_code, 0);
    rst = 0;
    send(8'h1C);
    chk("p1_event", key_event, 1);
    chk("p1_code", key_code, 8'h1C);
    chk("p1_make", key_make, 1);
    chk("p1_ext", key_extended, 0);
    chk("p1_held", held_count, 1);
    send(8'h1C);
    chk("rep_event", key_event, 0);
    send(8'h1C);
    send(8'hF0);
    send(8'h1C);
    chk("r1_event", key_event, 1);
    chk("r1_make", key_make, 0);
    chk("r1_held", held_count, 0);
    send(8'hE0); send(8'h75);
    chk("e_event", key_event, 1);
    chk("e_ext", key_extended, 1);
    chk("e_code", key_code, 8'h75);
    send(8'h75);
    chk("plain_ext", key_extended, 0);
    chk("plain_held", held_count, 2);
    send(8'hF0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("er_ext", key_extended, 1);
    chk("er_make", key_make, 0);
    chk("er_held", held_count, 0);
    foreach (full_set[i]) send(full_set[i]);
    send(8'h44);
    chk("full_event", key_event, 0);
    chk("full_flag", table_full, 1);
    chk("full_held", held_count, 8);
    send(8'hF0); send(8'h2D);
    chk("fr_event", key_event, 1);
    chk("fr_flag", table_full, 0);
    send(8'h44);
    chk("slot3_event", key_event, 1);
    chk("slot3_code", dut.scode_q[3], 8'h44);
    @(negedge clk);
    rst = 1; en = 1; data = 8'h1C;
    @(negedge clk);
    rst = 0; en = 0;
    chk("rst_en_held", held_count, 0);
    chk("rst_en_event", key_event, 0);
    send(8'hF0);
    errs = 0;
    repeat (T+5) begin @(negedge clk); errs += int'(seq_error); end
    chk("timeout_pulses", errs, 1);
    send(8'h1C);
    chk("to_press", key_make, 1);
    chk("to_event", key_event, 1);
    send(8'hF0); send(8'h33);
    chk("orphan_event", key_event, 0);
    send(8'hF0); send(8'hF0);
    chk("ff_err", seq_error, 1);
    send(8'hE0);
    pulse_reset();
    send(8'h75);
    chk("mid_rst_ext", key_extended, 0);
    chk("mid_rst_make", key_make, 1);
    put(8'h24, 0); put(8'h2D, 0); put(8'hF0, 0); put(8'h24, 1);
    chk("b2b_held", held_count, 2);
    repeat (3000) begin
      r = $urandom_range(0, 99);
      b = r < 15 ? 8'hE0 : r < 35 ? 8'hF0 : r < 40 ? igns[$urandom_range(0, 6)] : codes[$urandom_range(0, 11)];
      g = $urandom_range(0, 19);
      gap = g < 4 ? 0 : g < 18 ? $urandom_range(1, 3) : $urandom_range(T-2, T+3);
      put(b, gap);
      if ($urandom_range(0, 299) == 0) pulse_reset();
    end
    @(negedge clk);
    en = 0;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
